imem_responder: RTL and testbench

Instruction-memory responder that serves fetch requests from the ifu. It answers each byte-addressed fetch with the 32-bit instruction word after a fixed pipeline latency, using valid/ready handshakes on both request and response. A credit-limited response FIFO absorbs backpressure. A load port fills memory before execution, and a flush discards in-flight fetches on a redirect.

---
 rtl/imem_responder.sv | 169 ++++++++++++++++
 tb/tb_imem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves ifu fetches after a fixed latency through
// a short read pipeline and a credit-limited response FIFO, with program load
// and redirect flush.
module imem_responder #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [31:0]              resp_instr_o,
    output logic [31:0]              resp_addr_o,
    output logic                     resp_err_o,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
    input  logic [31:0]              ld_data_i,
    input  logic                     flush_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Misaligned pc or a word index past the end of memory (DEPTH is a power of two).
    function automatic logic fetch_err(input logic [31:0] addr);
        return (|addr[1:0]) || (|addr[31:AW+2]);
    endfunction

    // FIFO pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    logic [31:0]   mem [DEPTH];

    logic [CW-1:0] cnt;
    logic [CW-1:0] fill;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          push;
    logic          pop;

    logic [31:0]   fifo_addr  [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic          fifo_err   [FIFO_DEPTH];

    logic          vld_p0;
    logic [31:0]   addr_p0;
    logic [31:0]   instr_p0;
    logic          err_p0;

    logic          tail_vld;
    logic [31:0]   tail_addr;
    logic [31:0]   tail_instr;
    logic          tail_err;

    // cnt covers both pipeline and FIFO, so it alone throttles new requests.
    assign req_ready_o = !reset && !ld_en_i && !flush_i && (cnt < CW'(FIFO_DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    // ---- p0: accept cycle, memory read and error classification
    assign vld_p0   = accept;
    assign addr_p0  = req_addr_i;
    assign err_p0   = fetch_err(req_addr_i);
    assign instr_p0 = err_p0 ? NOP : mem[req_addr_i[AW+1:2]];

    // Program load port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en_i) mem[ld_addr_i] <= ld_data_i;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign tail_vld   = vld_p0;
            assign tail_addr  = addr_p0;
            assign tail_instr = instr_p0;
            assign tail_err   = err_p0;
        end else begin : g_pipe
            // Element k holds stage p(k+1).
            logic        vld_pn   [LATENCY-1];
            logic [31:0] addr_pn  [LATENCY-1];
            logic [31:0] instr_pn [LATENCY-1];
            logic        err_pn   [LATENCY-1];

            // ---- p1..p(LATENCY-1): valid bits shift, dropped on reset or flush
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < LATENCY - 1; k++) vld_pn[k] <= 1'b0;
                end else if (flush_i) begin
                    for (int k = 0; k < LATENCY - 1; k++) vld_pn[k] <= 1'b0;
                end else begin
                    vld_pn[0] <= vld_p0;
                    for (int k = 1; k < LATENCY - 1; k++) vld_pn[k] <= vld_pn[k-1];
                end
            end

            // Payload shifts alongside the valids; it is only meaningful when valid.
            always_ff @(posedge clk) begin
                addr_pn[0]  <= addr_p0;
                instr_pn[0] <= instr_p0;
                err_pn[0]   <= err_p0;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    addr_pn[k]  <= addr_pn[k-1];
                    instr_pn[k] <= instr_pn[k-1];
                    err_pn[k]   <= err_pn[k-1];
                end
            end

            assign tail_vld   = vld_pn[LATENCY-2];
            assign tail_addr  = addr_pn[LATENCY-2];
            assign tail_instr = instr_pn[LATENCY-2];
            assign tail_err   = err_pn[LATENCY-2];
        end
    endgenerate

    // ---- FIFO: last pipeline stage is written at the end of its cycle
    assign push = tail_vld && !flush_i;
    assign pop  = resp_valid_o && resp_ready_i;

    // Pointers and counters; flush empties everything, a same-cycle pop is simply absorbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage; cannot overflow because cnt bounds pipeline plus FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= tail_addr;
            fifo_instr[wr_ptr] <= tail_instr;
            fifo_err[wr_ptr]   <= tail_err;
        end
    end

    assign resp_valid_o = (fill != '0);
    assign resp_instr_o = resp_valid_o ? fifo_instr[rd_ptr] : '0;
    assign resp_addr_o  = resp_valid_o ? fifo_addr[rd_ptr]  : '0;
    assign resp_err_o   = resp_valid_o ? fifo_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_imem_responder;

    localparam int DEPTH      = 256;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_instr_o;
    logic [31:0] resp_addr_o;
    logic        resp_err_o;
    logic        ld_en_i = 1'b0;
    logic [7:0]  ld_addr_i = '0;
    logic [31:0] ld_data_i = '0;
    logic        flush_i = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] instr;
        int          due;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] mem_m [DEPTH];

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_instr_o(resp_instr_o), .resp_addr_o(resp_addr_o), .resp_err_o(resp_err_o),
        .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return !reset && !ld_en_i && !flush_i && (mq.size() < FIFO_DEPTH);
    endfunction

    function automatic logic exp_valid();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    function automatic logic [64:0] exp_head();
        if (exp_valid()) return {mq[0].err, mq[0].addr, mq[0].instr};
        return '0;
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        logic acc, pp;
        acc = req_valid_i && exp_ready();
        pp  = exp_valid() && resp_ready_i;
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (flush_i || reset) mq.delete();
        if (acc) begin
            ent_t e;
            e.addr  = req_addr_i;
            e.err   = (req_addr_i[1:0] != 2'b00) || (req_addr_i >= 32'(DEPTH * 4));
            e.instr = e.err ? NOP : mem_m[req_addr_i[9:2]];
            e.due   = cyc + LATENCY;
            mq.push_back(e);
        end
        if (ld_en_i) mem_m[ld_addr_i] = ld_data_i;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid_i = 1'b0; ld_en_i = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", req_ready_o); end
        total++; if ({resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o} !== 66'd0) begin
            bad++; $display("FAIL reset_outputs got=%0b/%0b/%h/%h exp=all zero", resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o); end
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", req_ready_o); end
        tick();
    endtask

    task automatic test_load_all();
        for (int i = 0; i < DEPTH; i++) begin
            ld_en_i = 1'b1; ld_addr_i = 8'(i); ld_data_i = $urandom;
            req_valid_i = 1'($urandom_range(0, 1)); req_addr_i = 32'(i * 4);
            #1;
            if (i % 32 == 0) begin
                total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL load_ready got=%0b exp=0", req_ready_o); end
            end
            tick();
        end
        idle_inputs();
        #1;
        total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL load_no_resp got=%0b exp=0", resp_valid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        int nresp = 0;
        words[0] = 32'h0034_5678; words[1] = 32'h0034_5478;
        words[2] = 32'h0034_5679; words[3] = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            ld_en_i = 1'b1; ld_addr_i = 8'(i); ld_data_i = words[i];
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            req_valid_i = (i < 4); req_addr_i = 32'(i * 4);
            #1;
            total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=1", i, req_ready_o); end
            total++; if (resp_valid_o !== exp_valid()) begin bad++; $display("FAIL b2b_valid cyc=%0d got=%0b exp=%0b", i, resp_valid_o, exp_valid()); end
            total++; if ({resp_err_o, resp_addr_o, resp_instr_o} !== exp_head()) begin
                bad++; $display("FAIL b2b_head cyc=%0d got=%h exp=%h", i, {resp_err_o, resp_addr_o, resp_instr_o}, exp_head()); end
            if (i >= 2 && i < 6) begin
                total++; if (resp_instr_o !== words[i-2] || resp_err_o !== 1'b0) begin
                    bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i - 2, resp_instr_o, words[i-2]); end
            end
            if (resp_valid_o) nresp++;
            tick();
        end
        total++; if (nresp !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", nresp); end
    endtask

    task automatic test_err();
        int nerr = 0;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            req_valid_i = (i < 2); req_addr_i = (i == 0) ? 32'h6 : 32'h400;
            #1;
            total++; if ({resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o} !== {exp_valid(), exp_head()}) begin
                bad++; $display("FAIL err_head cyc=%0d got=%0b/%h exp=%0b/%h", i, resp_valid_o, {resp_err_o, resp_addr_o, resp_instr_o}, exp_valid(), exp_head()); end
            if (resp_valid_o && resp_err_o && resp_instr_o === NOP) nerr++;
            tick();
        end
        total++; if (nerr !== 2) begin bad++; $display("FAIL err_count got=%0d exp=2", nerr); end
    endtask

    task automatic test_backpressure();
        int nacc = 0;
        int npop = 0;
        idle_inputs();
        resp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1; req_addr_i = 32'(16 + i * 4);
            #1;
            total++; if (req_ready_o !== exp_ready()) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b exp=%0b", i, req_ready_o, exp_ready()); end
            if (req_ready_o) nacc++;
            tick();
        end
        total++; if (nacc !== FIFO_DEPTH) begin bad++; $display("FAIL bp_accepts got=%0d exp=%0d", nacc, FIFO_DEPTH); end
        req_valid_i = 1'b0; resp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if ({resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o} !== {exp_valid(), exp_head()}) begin
                bad++; $display("FAIL bp_drain cyc=%0d got=%0b/%h exp=%0b/%h", i, resp_valid_o, {resp_err_o, resp_addr_o, resp_instr_o}, exp_valid(), exp_head()); end
            if (resp_valid_o) npop++;
            tick();
        end
        total++; if (npop !== FIFO_DEPTH) begin bad++; $display("FAIL bp_pops got=%0d exp=%0d", npop, FIFO_DEPTH); end
        #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b exp=1", req_ready_o); end
    endtask

    task automatic test_flush();
        int lat = -1;
        idle_inputs();
        resp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1; req_addr_i = 32'(i * 4);
            tick();
        end
        flush_i = 1'b1;
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", req_ready_o); end
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (resp_valid_o !== 1'b0) begin bad++; $display("FAIL flush_stale cyc=%0d got=%0b exp=0", i, resp_valid_o); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            req_valid_i = (i == 0); req_addr_i = 32'h8;
            #1;
            total++; if ({resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o} !== {exp_valid(), exp_head()}) begin
                bad++; $display("FAIL flush_after cyc=%0d got=%0b/%h exp=%0b/%h", i, resp_valid_o, {resp_err_o, resp_addr_o, resp_instr_o}, exp_valid(), exp_head()); end
            if (resp_valid_o && lat < 0) lat = i;
            tick();
        end
        total++; if (lat !== LATENCY) begin bad++; $display("FAIL flush_latency got=%0d exp=%0d", lat, LATENCY); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        resp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid_i = 1'b1; req_addr_i = 32'(i * 4);
            tick();
        end
        req_valid_i = 1'b0;
        #1;
        total++; if (resp_valid_o !== 1'b1) begin bad++; $display("FAIL arst_before got=%0b exp=1", resp_valid_o); end
        #1 reset = 1'b1;
        #1;
        total++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || resp_instr_o !== 32'd0 || resp_addr_o !== 32'd0) begin
            bad++; $display("FAIL arst_immediate got=%0b/%0b/%h/%h exp=0/0/0/0", resp_valid_o, req_ready_o, resp_instr_o, resp_addr_o); end
        mq.delete();
        reset = 1'b0;
        #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL arst_cnt_clear got=%0b exp=1", req_ready_o); end
        resp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = (i == 0); req_addr_i = 32'h0;
            #1;
            if (i == LATENCY) begin
                total++; if (resp_valid_o !== 1'b1 || resp_instr_o !== 32'h0034_5678) begin
                    bad++; $display("FAIL arst_mem_kept got=%0b/%h exp=1/00345678", resp_valid_o, resp_instr_o); end
            end
            tick();
        end
    endtask

    task automatic test_load_priority();
        logic [31:0] nd;
        nd = $urandom;
        idle_inputs();
        ld_en_i = 1'b1; ld_addr_i = 8'd5; ld_data_i = nd;
        req_valid_i = 1'b1; req_addr_i = 32'd20;
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL ldpri_ready got=%0b exp=0", req_ready_o); end
        tick();
        ld_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = (i == 0);
            #1;
            if (i == 0) begin
                total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL ldpri_ready_next got=%0b exp=1", req_ready_o); end
            end
            total++; if (resp_valid_o !== (i == LATENCY)) begin bad++; $display("FAIL ldpri_valid cyc=%0d got=%0b", i, resp_valid_o); end
            if (i == LATENCY) begin
                total++; if (resp_instr_o !== nd) begin bad++; $display("FAIL ldpri_data got=%h exp=%h", resp_instr_o, nd); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 500; i++) begin
            req_valid_i  = ($urandom_range(0, 3) != 0);
            resp_ready_i = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 24) == 0);
            ld_en_i      = ($urandom_range(0, 19) == 0);
            ld_addr_i    = 8'($urandom_range(0, DEPTH - 1));
            ld_data_i    = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      req_addr_i = {22'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'b01};
            else if (r == 1) req_addr_i = {$urandom_range(1, 32'h003F_FFFF), 10'($urandom_range(0, 255) * 4)};
            else             req_addr_i = 32'($urandom_range(0, DEPTH - 1) * 4);
            #1;
            total++; if (req_ready_o !== exp_ready()) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, req_ready_o, exp_ready()); end
            total++; if ({resp_valid_o, resp_err_o, resp_addr_o, resp_instr_o} !== {exp_valid(), exp_head()}) begin
                bad++; $display("FAIL rnd_head cyc=%0d got=%0b/%h exp=%0b/%h", i, resp_valid_o, {resp_err_o, resp_addr_o, resp_instr_o}, exp_valid(), exp_head()); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_all();
        test_back_to_back();
        test_err();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_load_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
